// File: rtl/flash_boot_loader.sv
// Post-reset boot copier: one SPI READ (0x03) burst from flash, packed little-endian
// into 16-bit words and written over Wishbone; the CPU is held in reset until it finishes.
module flash_boot_loader #(
    parameter logic [23:0] FLASH_ADDR = 24'h000000,
    parameter logic [18:0] DEST_ADR   = 19'h7F000,
    parameter int unsigned WORDS      = 4096,
    parameter int unsigned CLK_DIV    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [15:0] wb_dat_o,
    input  logic [15:0] wb_dat_i,
    output logic [18:0] wb_adr_o,
    output logic        wb_we_o,
    output logic        wb_tga_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    output logic [1:0]  wb_sel_o,
    input  logic        wb_ack_i,
    output logic        spi_sck,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        busy,
    output logic        done,
    output logic        cpu_rst_o
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = 5;
    localparam int unsigned IDX_W = 16;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);
    localparam logic [31:0]      CMD_WORD = {8'h03, FLASH_ADDR};

    typedef enum logic [2:0] {
        CMD     = 3'd0,
        READ_LO = 3'd1,
        READ_HI = 3'd2,
        WB_WR   = 3'd3,
        DONE    = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               sck_q, sck_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic               mosi_q, mosi_d;
    logic               cs_n_q, cs_n_d;
    logic [7:0]         lo_q, lo_d;
    logic [7:0]         hi_q, hi_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               stb_q, stb_d;
    logic               we_q, we_d;
    logic [1:0]         sel_q, sel_d;
    logic [18:0]        adr_q, adr_d;
    logic [15:0]        dat_q, dat_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cpu_rst_q, cpu_rst_d;
    logic               sck_rise_c;
    logic               bit_end_c;
    logic               prime_c;
    logic               unused_rdata;

    // Read data is never consumed: the loader only writes.
    assign unused_rdata = ^wb_dat_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CMD;
            div_q     <= '0;
            sck_q     <= 1'b0;
            bit_q     <= '0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            lo_q      <= '0;
            hi_q      <= '0;
            idx_q     <= '0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cpu_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            sck_q     <= sck_d;
            bit_q     <= bit_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            idx_q     <= idx_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cpu_rst_q <= cpu_rst_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        sck_d      = sck_q;
        bit_d      = bit_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        idx_d      = idx_q;
        stb_d      = stb_q;
        we_d       = we_q;
        sel_d      = sel_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        busy_d     = busy_q;
        done_d     = done_q;
        cpu_rst_d  = cpu_rst_q;
        sck_rise_c = 1'b0;
        bit_end_c  = 1'b0;
        prime_c    = 1'b0;

        // SCK engine: CLK_DIV cycles low then CLK_DIV high per bit; frozen outside the shift states.
        if ((state_q == CMD || state_q == READ_LO || state_q == READ_HI) && !cs_n_q) begin
            if (div_q == DIV_LAST) begin
                div_d      = '0;
                sck_d      = !sck_q;
                sck_rise_c = !sck_q;
                bit_end_c  = sck_q;
            end else begin
                div_d = div_q + 1'b1;
            end
        end

        case (state_q)
            CMD: begin
                if (cs_n_q) begin
                    prime_c = 1'b1;
                end else if (bit_end_c) begin
                    if (bit_q == BIT_W'(31)) begin
                        state_d = READ_LO;
                        bit_d   = '0;
                        mosi_d  = 1'b0;
                    end else begin
                        bit_d  = bit_q + BIT_W'(1);
                        mosi_d = CMD_WORD[BIT_W'(30) - bit_q];
                    end
                end
            end
            READ_LO: begin
                if (sck_rise_c) begin
                    lo_d = {lo_q[6:0], spi_miso};
                end
                if (bit_end_c) begin
                    if (bit_q == BIT_W'(7)) begin
                        state_d = READ_HI;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            READ_HI: begin
                if (sck_rise_c) begin
                    hi_d = {hi_q[6:0], spi_miso};
                end
                if (bit_end_c) begin
                    if (bit_q == BIT_W'(7)) begin
                        state_d = WB_WR;
                        bit_d   = '0;
                        stb_d   = 1'b1;
                        we_d    = 1'b1;
                        sel_d   = 2'b11;
                        adr_d   = DEST_ADR + 19'(idx_q);
                        dat_d   = {hi_q, lo_q};
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            WB_WR: begin
                // Flash burst stays open (CS low, SCK low) while the slave stalls.
                if (wb_ack_i) begin
                    stb_d = 1'b0;
                    we_d  = 1'b0;
                    sel_d = '0;
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d   = DONE;
                        cs_n_d    = 1'b1;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        cpu_rst_d = 1'b0;
                    end else begin
                        state_d = READ_LO;
                        bit_d   = '0;
                        div_d   = '0;
                        sck_d   = 1'b0;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    prime_c = 1'b1;
                end
            end
            default: begin
                state_d = CMD;
            end
        endcase

        // Open a fresh READ burst: first command bit is presented in the very next cycle.
        if (prime_c) begin
            state_d = CMD;
            cs_n_d  = 1'b0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            mosi_d  = CMD_WORD[31];
            bit_d   = '0;
            div_d   = '0;
            sck_d   = 1'b0;
            idx_d   = '0;
        end
    end

    assign wb_dat_o  = dat_q;
    assign wb_adr_o  = adr_q;
    assign wb_we_o   = we_q;
    assign wb_tga_o  = 1'b0;
    assign wb_stb_o  = stb_q;
    assign wb_cyc_o  = stb_q;
    assign wb_sel_o  = sel_q;
    assign spi_sck   = sck_q;
    assign spi_cs_n  = cs_n_q;
    assign spi_mosi  = mosi_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cpu_rst_o = cpu_rst_q;

endmodule

// File: doc/flash_boot_loader.md
# flash_boot_loader

Wishbone master that fills the 8 KB boot ROM window at 0xFE000 from an external SPI flash after reset. It issues a single SPI READ (0x03) burst, packs bytes into 16-bit words and writes each word over Wishbone. It holds the CPU in reset until the copy completes. It sits between the SPI flash pins and the Wishbone interconnect, alongside the boot ROM slave.

## Interface
- FLASH_ADDR, 24'h000000, byte address in flash where the image starts
- DEST_ADR, 19'h7F000, Wishbone word address (`wb_adr_o[19:1]`) of the first destination word (0xFE000 >> 1)
- WORDS, 4096, number of 16-bit words to copy (1..65535)
- CLK_DIV, 2, `clk` cycles per SCK half-period (≥1)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; re-runs the copy when in DONE, ignored otherwise
- wb_dat_o  out  16  write data {high byte, low byte}
- wb_dat_i  in  16  unused (no reads issued)
- wb_adr_o  out  19  word address, bits [19:1]
- wb_we_o  out  1  always 1 during a cycle
- wb_tga_o  out  1  always 0 (memory space)
- wb_stb_o, wb_cyc_o  out  1 each  asserted together
- wb_sel_o  out  2  2'b11 during a cycle
- wb_ack_i  in  1  slave acknowledge
- spi_sck  out  1  SPI clock, mode 0, idle low
- spi_cs_n  out  1  flash chip select, active low
- spi_mosi  out  1  serial command/address out
- spi_miso  in  1  serial data in
- busy  out  1  high while a copy is in progress
- done  out  1  high once the copy has completed
- cpu_rst_o  out  1  CPU reset request, high until the first copy completes

## Operation
- States: CMD, READ_LO, READ_HI, WB_WR, DONE. Reset enters CMD, so the copy starts automatically.
- CMD: `spi_cs_n`=0. Shift 32 bits MSB-first: 0x03, then FLASH_ADDR[23:0].
- READ_LO: shift 8 bits in, MSB-first, into the low byte. READ_HI: shift 8 bits in, MSB-first, into the high byte. The first flash byte is the low byte (little-endian).
- WB_WR: `wb_cyc_o`=`wb_stb_o`=1, `wb_we_o`=1, `wb_sel_o`=2'b11, `wb_tga_o`=0.
  - `wb_adr_o` = DEST_ADR + word_index, computed mod 2^19.
  - `wb_dat_o` = {hi, lo}. Outputs are held stable until `wb_ack_i`.
  - On the cycle `wb_ack_i`=1: word_index increments. If it was WORDS-1, go to DONE; otherwise go to READ_LO.
- During WB_WR, SCK stays low and `spi_cs_n` stays 0. The flash burst is paused, not restarted.
- DONE: `spi_cs_n`=1, `done`=1, `busy`=0, `cpu_rst_o`=0. A `start` pulse clears `done` and word_index, then enters CMD. `cpu_rst_o` stays 0 on re-runs.
- word_index is 16 bits wide.
- Reset at any point, including mid-burst or mid-write: all outputs return to reset values immediately and the copy restarts from CMD.

## Timing
- Reset values: `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0, `wb_cyc_o`=`wb_stb_o`=0, `wb_we_o`=0, `wb_sel_o`=0, `wb_adr_o`=0, `wb_dat_o`=0, `wb_tga_o`=0, `busy`=0, `done`=0, `cpu_rst_o`=1.
- First cycle after `rst` falls: `spi_cs_n`=0, `busy`=1, with `spi_mosi` = bit 7 of 0x03.
- SPI bit timing:
  - Each bit lasts 2·CLK_DIV cycles: CLK_DIV cycles with SCK low, then CLK_DIV cycles with SCK high.
  - MOSI changes only while SCK is low, at bit start.
  - MISO is sampled on the clk edge at which SCK goes 0→1.
- The READ_HI→WB_WR transition happens in the cycle after the 8th high-byte bit's SCK-high phase ends. `wb_stb_o` rises in that cycle.
- With an immediate ack (ack = stb), `wb_stb_o` is high for exactly 1 cycle, and SCK resumes low on the next cycle.
- `wb_stb_o` deasserts on the cycle after ack is sampled.
- Per-word time with zero-wait ack: 32·CLK_DIV + 1 cycles. Full copy: 64·CLK_DIV + WORDS·(32·CLK_DIV+1) cycles plus 1 cycle for entry into DONE.
- Transition into DONE: `spi_cs_n`, `done`, `busy` and `cpu_rst_o` all change in the same cycle.

## Test plan
- Default parameters with a flash model holding bytes 0x00,0x01,0x02,… → MOSI carries 0x03 0x00 0x00 0x00. Write k has adr = 0x7F000+k and dat = {2k+1, 2k} mod 256. Exactly 4096 writes; the last is at 0x7FFFF. Then `done`=1, `cpu_rst_o`=0, `spi_cs_n`=1.
- WORDS=3, CLK_DIV=1, slave ack delayed 5 cycles → stb/cyc/adr/dat held for 6 cycles each. SCK stays low during each wait. MISO data continues without gap: words 0x0100, 0x0302, 0x0504.
- DEST_ADR=19'h7FFFF, WORDS=2 → addresses 0x7FFFF then 0x00000 (wrap).
- Assert `rst` during the 2nd word's READ_HI for 1 cycle → all outputs take reset values next cycle. The copy restarts with a new 0x03 command, and the first write goes to DEST_ADR with the flash's first two bytes.
- From DONE, pulse `start` → `done` drops next cycle and a second identical copy runs. `cpu_rst_o` stays 0 throughout. A `start` pulse mid-copy has no effect.
- FLASH_ADDR=24'h123456 → command bytes on MOSI are 0x03 0x12 0x34 0x56, with MSB first in each byte.
